// File: rtl/bcd_counter_7seg_scan.sv
// Multi-digit BCD up/down counter driving a time-multiplexed 7-segment display.
// Count updates one cycle after its controls; seg/dig_sel follow one cycle later; no backpressure.
module bcd_counter_7seg_scan #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 4,
   parameter int ACTIVE_LOW = 0,
   parameter int BLANK_LZ   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic                  load_err,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [6:0]            seg
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIGITS-1:0] SEL_POL = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]        SEG_POL = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [DIGITS-1:0] SEL_RST = SEL_POL ^ DIGITS'(1);
   localparam logic [6:0]        SEG_RST = SEG_POL ^ 7'b1111110;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b1111110;
         4'd1:    glyph = 7'b0110000;
         4'd2:    glyph = 7'b1101101;
         4'd3:    glyph = 7'b1111001;
         4'd4:    glyph = 7'b0110011;
         4'd5:    glyph = 7'b1011011;
         4'd6:    glyph = 7'b1011111;
         4'd7:    glyph = 7'b1110000;
         4'd8:    glyph = 7'b1111111;
         4'd9:    glyph = 7'b1111011;
         default: glyph = 7'b0000000;
      endcase
   endfunction

   logic [4*DIGITS-1:0] count_q, count_d;
   logic                carry_q, carry_d;
   logic                load_err_q, load_err_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
   logic [6:0]          seg_q, seg_d;

   logic [4*DIGITS-1:0] stepped, loaded;
   logic [3:0]          nib, sel_nib;
   logic                chain, bad_nib, pre_last, zero_run, sel_blank;

   // Counter: ripple the +/-1 through the digits; a chain surviving the top digit is a wrap.
   always_comb begin
      stepped = count_q;
      loaded  = '0;
      nib     = '0;
      chain   = 1'b1;
      bad_nib = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = count_q[4*i +: 4];
         if (chain) begin
            if (up) begin
               if (nib == 4'd9) nib = 4'd0;
               else begin
                  nib   = nib + 4'd1;
                  chain = 1'b0;
               end
            end else begin
               if (nib == 4'd0) nib = 4'd9;
               else begin
                  nib   = nib - 4'd1;
                  chain = 1'b0;
               end
            end
         end
         stepped[4*i +: 4] = nib;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) bad_nib = 1'b1;
         else loaded[4*i +: 4] = load_val[4*i +: 4];
      end

      count_d    = count_q;
      carry_d    = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         count_d    = loaded;
         load_err_d = bad_nib;
      end else if (en) begin
         count_d = stepped;
         carry_d = chain;
      end
   end

   // Display registers are fed from the next scan index so dig_sel tracks the index with no lag.
   always_comb begin
      pre_last = (pre_q == PRE_W'(SCAN_DIV - 1));
      pre_d    = pre_last ? '0 : pre_q + PRE_W'(1);
      idx_d    = idx_q;
      if (pre_last) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

      sel_nib   = '0;
      sel_blank = 1'b0;
      zero_run  = 1'b1;
      dig_sel_d = SEL_POL;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (count_q[4*i +: 4] == 4'd0);
         if (idx_d == IDX_W'(i)) begin
            sel_nib      = count_q[4*i +: 4];
            sel_blank    = (BLANK_LZ != 0) && (i > 0) && zero_run;
            dig_sel_d[i] = ~SEL_POL[i];
         end
      end
      seg_d = SEG_POL ^ (sel_blank ? 7'b0000000 : glyph(sel_nib));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         carry_q    <= 1'b0;
         load_err_q <= 1'b0;
         pre_q      <= '0;
         idx_q      <= '0;
         dig_sel_q  <= SEL_RST;
         seg_q      <= SEG_RST;
      end else begin
         count_q    <= count_d;
         carry_q    <= carry_d;
         load_err_q <= load_err_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         dig_sel_q  <= dig_sel_d;
         seg_q      <= seg_d;
      end
   end

   assign count    = count_q;
   assign carry    = carry_q;
   assign load_err = load_err_q;
   assign dig_sel  = dig_sel_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_counter_7seg_scan.sv
// Bench for bcd_counter_7seg_scan: directed plan plus random steps against an integer-valued model.
module tb_bcd_counter_7seg_scan;
   localparam int D  = 4;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst, en, up, load;
   logic [15:0]   load_val;
   logic [15:0]   count1, count2;
   logic          carry1, carry2, lerr1, lerr2;
   logic [3:0]    dig1, dig2;
   logic [6:0]    seg1, seg2;

   int vectors = 0;
   int miscompares = 0;

   // model state: count as a plain integer, cycles since last reset
   int cnt = 0;
   int t = 0;

   logic [6:0] gly [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   bcd_counter_7seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut_hi (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count1), .carry(carry1), .load_err(lerr1), .dig_sel(dig1), .seg(seg1));

   bcd_counter_7seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut_lo (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count2), .carry(carry2), .load_err(lerr2), .dig_sel(dig2), .seg(seg2));

   always #5 clk = ~clk;

   function automatic int p10(input int i);
      int r = 1;
      for (int k = 0; k < i; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] b;
      for (int i = 0; i < D; i++) b[4*i +: 4] = 4'((v / p10(i)) % 10);
      return b;
   endfunction

   function automatic logic [6:0] render(input int v, input int idx, input bit blz);
      if (blz && idx > 0 && v < p10(idx)) return 7'b0000000;
      return gly[(v / p10(idx)) % 10];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s at t=%0d: observed %h expected %h", tag, t, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit l, input logic [15:0] lv, input bit e, input bit u);
      int         old, idx, lv_int;
      bit         exp_c, exp_le;
      logic [6:0] exp_s1, exp_s2;
      logic [3:0] one, exp_d1, exp_d2;
      rst = r; load = l; load_val = lv; en = e; up = u;
      @(posedge clk);
      old = cnt; exp_c = 0; exp_le = 0;
      if (r) begin
         t = 0; cnt = 0; idx = 0;
         exp_s1 = gly[0];
         exp_s2 = ~gly[0];
      end else begin
         t++;
         idx = (t / SD) % D;
         exp_s1 = render(old, idx, 1'b1);
         exp_s2 = ~render(old, idx, 1'b0);
         if (l) begin
            lv_int = 0;
            for (int i = 0; i < D; i++) begin
               if (lv[4*i +: 4] > 4'd9) exp_le = 1;
               else lv_int += int'(lv[4*i +: 4]) * p10(i);
            end
            cnt = lv_int;
         end else if (e) begin
            if (u) begin
               exp_c = (old == p10(D) - 1);
               cnt = (old + 1) % p10(D);
            end else begin
               exp_c = (old == 0);
               cnt = (old + p10(D) - 1) % p10(D);
            end
         end
      end
      one = 4'b0001 << idx;
      exp_d1 = one;
      exp_d2 = ~one;
      #1;
      chk("count_hi", 32'(count1), 32'(to_bcd(cnt)));
      chk("carry_hi", 32'(carry1), 32'(exp_c));
      chk("lerr_hi",  32'(lerr1),  32'(exp_le));
      chk("dig_hi",   32'(dig1),   32'(exp_d1));
      chk("seg_hi",   32'(seg1),   32'(exp_s1));
      chk("count_lo", 32'(count2), 32'(to_bcd(cnt)));
      chk("carry_lo", 32'(carry2), 32'(exp_c));
      chk("lerr_lo",  32'(lerr2),  32'(exp_le));
      chk("dig_lo",   32'(dig2),   32'(exp_d2));
      chk("seg_lo",   32'(seg2),   32'(exp_s2));
   endtask

   initial begin
      logic [15:0] lv;
      rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
      #1;
      step(1, 0, 16'h0000, 0, 0);
      repeat (32) step(0, 0, 16'h0000, 0, 0);

      step(0, 1, 16'h9998, 0, 0);
      repeat (3) step(0, 0, 16'h0000, 1, 1);

      step(0, 1, 16'h0001, 0, 0);
      repeat (3) step(0, 0, 16'h0000, 1, 0);

      step(0, 1, 16'h0A37, 0, 0);
      repeat (16) step(0, 0, 16'h0000, 0, 0);

      step(0, 1, 16'h1234, 1, 1);
      for (int k = 0; k < 20 && !(((t / SD) % D) == 2 && (t % SD) == 1); k++)
         step(0, 0, 16'h0000, 0, 0);
      step(1, 0, 16'h0000, 1, 1);
      repeat (6) step(0, 0, 16'h0000, 0, 0);

      step(0, 1, 16'h0005, 0, 0);
      repeat (20) step(0, 0, 16'h0000, 0, 0);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom);
            1:       lv = to_bcd(9990 + int'($urandom_range(0, 9)));
            2:       lv = to_bcd(int'($urandom_range(0, 12)));
            default: lv = to_bcd(int'($urandom_range(0, 9999)));
         endcase
         step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, lv,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
